uart_access_arbiter: RTL and testbench

Arbitrates ownership of the shared UART among `NUM_REQ` bus requesters (one per core). It accepts acquire and release commands from each requester's access-ID request path and returns one response byte per command on that requester's grant path. It holds at most one owner and queues the others in round-robin order. An idle owner is revoked after a programmable number of cycles, so a stalled core cannot lock the UART.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_access_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_uart_access_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: access-arbiter response codes, command layout and FSM states.
package uart_pkg;

    localparam logic [1:0] ACC_RSP_GRANT   = 2'b10;
    localparam logic [1:0] ACC_RSP_RELEASE = 2'b00;
    localparam logic [1:0] ACC_RSP_ERR     = 2'b01;

    localparam int ACC_CMD_RELEASE_BIT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } acc_state_e;

    // Response byte: code in [7:6] OR-ed over the 7-bit requester ID.
    function automatic logic [7:0] acc_rsp_byte(input logic [1:0] code, input logic [6:0] id);
        return {code, 6'b000000} | {1'b0, id};
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// One-hot round-robin picker: first set request at or after ptr_i, wrapping to index 0.
module uart_rr_pick #(
    parameter int  N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Two passes: indices at/above the pointer first, then the wrapped lower indices.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (IW'(j) >= ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (IW'(j) < ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_access_arbiter.sv
// Arbitrates UART ownership among NUM_REQ requesters with round-robin queuing
// of waiting acquirers and revocation of an owner that stays idle too long.
module uart_access_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  TMO_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic [NUM_REQ-1:0][7:0] req_data_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0][7:0] gnt_data_o,
    output logic [NUM_REQ-1:0]      gnt_valid_o,
    input  logic [NUM_REQ-1:0]      gnt_ready_i,
    input  logic [NUM_REQ-1:0]      activity_i,
    input  logic [TMO_W-1:0]        hold_timeout_i,
    output logic                    owner_valid_o,
    output logic [IDX_W-1:0]        owner_o,
    output logic [6:0]              owner_id_o,
    output logic [NUM_REQ-1:0]      revoke_o
);

    acc_state_e                state_r, state_s;
    logic [NUM_REQ-1:0]        pending_r, pending_s;
    logic [NUM_REQ-1:0][6:0]   pend_id_r, pend_id_s;
    logic [IDX_W-1:0]          rr_r, rr_s;
    logic [IDX_W-1:0]          owner_r, owner_s;
    logic [6:0]                owner_id_r, owner_id_s;
    logic [TMO_W-1:0]          cnt_r, cnt_s;
    logic [NUM_REQ-1:0]        gnt_valid_r, gnt_valid_s;
    logic [NUM_REQ-1:0][7:0]   gnt_data_r, gnt_data_s;
    logic [NUM_REQ-1:0]        revoke_r, revoke_s;

    logic [NUM_REQ-1:0]        eligible_s;
    logic [NUM_REQ-1:0]        acc_gnt_s, hand_gnt_s;
    logic [IDX_W-1:0]          acc_idx_s, hand_idx_s;
    logic                      acc_any_s, hand_any_s;
    logic                      handoff_s;
    logic [7:0]                cmd_data_s;
    logic                      cmd_rel_s;
    logic [6:0]                cmd_id_s;
    logic                      owner_act_s;
    logic                      timeout_hit_s;

    assign eligible_s = req_valid_i & ~gnt_valid_r & ~pending_r;
    assign handoff_s  = (state_r == IDLE) && hand_any_s;

    uart_rr_pick #(.N(NUM_REQ)) u_acc_pick (
        .req_i (eligible_s),
        .ptr_i (rr_r),
        .gnt_o (acc_gnt_s),
        .idx_o (acc_idx_s),
        .any_o (acc_any_s)
    );

    uart_rr_pick #(.N(NUM_REQ)) u_hand_pick (
        .req_i (pending_r),
        .ptr_i (rr_r),
        .gnt_o (hand_gnt_s),
        .idx_o (hand_idx_s),
        .any_o (hand_any_s)
    );

    assign cmd_data_s    = req_data_i[acc_idx_s];
    assign cmd_rel_s     = cmd_data_s[ACC_CMD_RELEASE_BIT];
    assign cmd_id_s      = cmd_data_s[6:0];
    assign owner_act_s   = activity_i[owner_r];
    assign timeout_hit_s = (hold_timeout_i != '0) && !owner_act_s &&
                           (cnt_r == (hold_timeout_i - TMO_W'(1)));

    // Command acceptance; a pending handoff blocks new commands for that cycle.
    always_comb begin
        if (handoff_s) begin
            req_ready_o = '0;
        end else begin
            req_ready_o = acc_gnt_s;
        end
    end

    // Next-state and next-output logic of the ownership FSM.
    always_comb begin
        state_s     = state_r;
        pending_s   = pending_r;
        pend_id_s   = pend_id_r;
        rr_s        = rr_r;
        owner_s     = owner_r;
        owner_id_s  = owner_id_r;
        cnt_s       = cnt_r;
        gnt_valid_s = gnt_valid_r & ~gnt_ready_i;
        gnt_data_s  = gnt_data_r;
        revoke_s    = '0;

        if (acc_any_s && !handoff_s) begin
            if (acc_idx_s == IDX_W'(NUM_REQ - 1)) begin
                rr_s = '0;
            end else begin
                rr_s = acc_idx_s + IDX_W'(1);
            end
        end else begin
            rr_s = rr_r;
        end

        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (handoff_s) begin
                    state_s                = BUSY;
                    owner_s                = hand_idx_s;
                    owner_id_s             = pend_id_r[hand_idx_s];
                    pending_s              = pending_r & ~hand_gnt_s;
                    gnt_valid_s            = gnt_valid_s | hand_gnt_s;
                    gnt_data_s[hand_idx_s] = acc_rsp_byte(ACC_RSP_GRANT, pend_id_r[hand_idx_s]);
                end else if (acc_any_s) begin
                    gnt_valid_s[acc_idx_s] = 1'b1;
                    if (cmd_rel_s) begin
                        gnt_data_s[acc_idx_s] = acc_rsp_byte(ACC_RSP_ERR, cmd_id_s);
                    end else begin
                        state_s               = BUSY;
                        owner_s               = acc_idx_s;
                        owner_id_s            = cmd_id_s;
                        gnt_data_s[acc_idx_s] = acc_rsp_byte(ACC_RSP_GRANT, cmd_id_s);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (owner_act_s) begin
                    cnt_s = '0;
                end else begin
                    cnt_s = cnt_r + TMO_W'(1);
                end
                if (acc_any_s && (acc_idx_s == owner_r)) begin
                    // Owner commands take precedence over a coincident timeout.
                    gnt_valid_s[acc_idx_s] = 1'b1;
                    if (cmd_rel_s) begin
                        state_s               = IDLE;
                        owner_s               = '0;
                        owner_id_s            = '0;
                        cnt_s                 = '0;
                        gnt_data_s[acc_idx_s] = acc_rsp_byte(ACC_RSP_RELEASE, cmd_id_s);
                    end else begin
                        cnt_s                 = '0;
                        gnt_data_s[acc_idx_s] = acc_rsp_byte(ACC_RSP_GRANT, cmd_id_s);
                    end
                end else begin
                    if (acc_any_s) begin
                        if (cmd_rel_s) begin
                            gnt_valid_s[acc_idx_s] = 1'b1;
                            gnt_data_s[acc_idx_s]  = acc_rsp_byte(ACC_RSP_ERR, cmd_id_s);
                        end else begin
                            pending_s[acc_idx_s] = 1'b1;
                            pend_id_s[acc_idx_s] = cmd_id_s;
                        end
                    end else begin
                        pending_s = pending_r;
                    end
                    if (timeout_hit_s) begin
                        revoke_s[owner_r] = 1'b1;
                        state_s           = IDLE;
                        owner_s           = '0;
                        owner_id_s        = '0;
                        cnt_s             = '0;
                    end else begin
                        state_s = BUSY;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r     <= IDLE;
            pending_r   <= '0;
            pend_id_r   <= '0;
            rr_r        <= '0;
            owner_r     <= '0;
            owner_id_r  <= '0;
            cnt_r       <= '0;
            gnt_valid_r <= '0;
            gnt_data_r  <= '0;
            revoke_r    <= '0;
        end else begin
            state_r     <= state_s;
            pending_r   <= pending_s;
            pend_id_r   <= pend_id_s;
            rr_r        <= rr_s;
            owner_r     <= owner_s;
            owner_id_r  <= owner_id_s;
            cnt_r       <= cnt_s;
            gnt_valid_r <= gnt_valid_s;
            gnt_data_r  <= gnt_data_s;
            revoke_r    <= revoke_s;
        end
    end

    assign owner_valid_o = (state_r == BUSY);
    assign owner_o       = owner_r;
    assign owner_id_o    = owner_id_r;
    assign gnt_valid_o   = gnt_valid_r;
    assign gnt_data_o    = gnt_data_r;
    assign revoke_o      = revoke_r;

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Directed and randomized bench for uart_access_arbiter against a cycle-level behavioural model.
module tb_uart_access_arbiter;

    localparam int N  = 3;
    localparam int IW = $clog2(N);
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              arst_ni;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0][7:0] gnt_data;
    logic [N-1:0]      gnt_valid;
    logic [N-1:0]      gnt_ready;
    logic [N-1:0]      activity;
    logic [TW-1:0]     hold;
    logic              owner_valid;
    logic [IW-1:0]     owner;
    logic [6:0]        owner_id;
    logic [N-1:0]      revoke;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int         m_owner;
    logic [6:0] m_oid;
    bit [N-1:0] m_pend;
    logic [6:0] m_pid [N];
    int         m_rr;
    bit [N-1:0] m_gv;
    logic [7:0] m_gd [N];
    int         m_idle;
    bit [N-1:0] m_rev;
    bit [N-1:0] m_rdy;

    uart_access_arbiter #(.NUM_REQ(N), .TMO_W(TW)) dut (
        .clk_i          (clk),
        .arst_ni        (arst_ni),
        .req_data_i     (req_data),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .gnt_data_o     (gnt_data),
        .gnt_valid_o    (gnt_valid),
        .gnt_ready_i    (gnt_ready),
        .activity_i     (activity),
        .hold_timeout_i (hold),
        .owner_valid_o  (owner_valid),
        .owner_o        (owner),
        .owner_id_o     (owner_id),
        .revoke_o       (revoke)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_oid   = 7'd0;
        m_pend  = '0;
        m_rr    = 0;
        m_gv    = '0;
        m_idle  = 0;
        m_rev   = '0;
        m_rdy   = '0;
        for (int i = 0; i < N; i++) begin
            m_pid[i] = 7'd0;
            m_gd[i]  = 8'd0;
        end
    endtask

    // One clock of the arbitration rules, evaluated on the inputs present this cycle.
    task automatic model_step();
        int         hand, acc, old_owner;
        bit         owner_cmd, rel;
        bit [N-1:0] old_gv;
        logic [6:0] id;
        hand = -1; acc = -1; old_owner = m_owner; owner_cmd = 1'b0;
        m_rdy = '0; m_rev = '0; old_gv = m_gv;
        for (int i = 0; i < N; i++)
            if (m_gv[i] && gnt_ready[i]) m_gv[i] = 1'b0;
        if (old_owner < 0)
            for (int k = 0; k < N; k++)
                if (hand < 0 && m_pend[(m_rr + k) % N]) hand = (m_rr + k) % N;
        if (hand >= 0) begin
            m_pend[hand] = 1'b0;
            m_owner      = hand;
            m_oid        = m_pid[hand];
            m_gv[hand]   = 1'b1;
            m_gd[hand]   = 8'h80 | {1'b0, m_pid[hand]};
            m_idle       = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (acc < 0 && req_valid[i] && !old_gv[i] && !m_pend[i]) acc = i;
            end
            if (acc >= 0) begin
                m_rdy[acc] = 1'b1;
                m_rr       = (acc + 1) % N;
                rel        = req_data[acc][7];
                id         = req_data[acc][6:0];
                if (acc == old_owner) begin
                    owner_cmd = 1'b1;
                    m_gv[acc] = 1'b1;
                    if (rel) begin
                        m_gd[acc] = {1'b0, id};
                        m_owner   = -1;
                    end else begin
                        m_gd[acc] = 8'h80 | {1'b0, id};
                        m_idle    = 0;
                    end
                end else if (rel) begin
                    m_gv[acc] = 1'b1;
                    m_gd[acc] = 8'h40 | {1'b0, id};
                end else if (old_owner < 0) begin
                    m_owner   = acc;
                    m_oid     = id;
                    m_idle    = 0;
                    m_gv[acc] = 1'b1;
                    m_gd[acc] = 8'h80 | {1'b0, id};
                end else begin
                    m_pend[acc] = 1'b1;
                    m_pid[acc]  = id;
                end
            end
            if (old_owner >= 0 && !owner_cmd) begin
                if (activity[old_owner]) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (hold != 0 && m_idle == int'(hold)) begin
                        m_rev[old_owner] = 1'b1;
                        m_owner          = -1;
                        m_idle           = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("owner_valid", owner_valid, (m_owner >= 0));
        if (m_owner >= 0) begin
            chk("owner", owner, m_owner);
            chk("owner_id", owner_id, m_oid);
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("gnt_valid[%0d]", i), gnt_valid[i], m_gv[i]);
            if (m_gv[i]) chk($sformatf("gnt_data[%0d]", i), gnt_data[i], m_gd[i]);
        end
        chk("revoke", revoke, m_rev);
    endtask

    // Ready is sampled mid-cycle, registered outputs just after the edge.
    task automatic step();
        @(negedge clk);
        model_step();
        for (int i = 0; i < N; i++)
            chk($sformatf("req_ready[%0d]", i), req_ready[i], m_rdy[i]);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic issue(input bit [N-1:0] mask, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
        req_valid   = mask;
        step();
        req_valid   = '0;
    endtask

    initial begin
        arst_ni   = 1'b1;
        req_data  = '0;
        req_valid = '0;
        gnt_ready = '1;
        activity  = '0;
        hold      = '0;
        model_reset();
        #1 arst_ni = 1'b0;
        #3;
        chk("rst owner_valid", owner_valid, 1'b0);
        chk("rst owner", owner, 2'd0);
        chk("rst owner_id", owner_id, 7'd0);
        chk("rst gnt_valid", gnt_valid, 3'd0);
        chk("rst gnt_data", gnt_data, 24'd0);
        chk("rst revoke", revoke, 3'd0);
        @(negedge clk) arst_ni = 1'b1;
        @(posedge clk) #1;

        // Acquire in IDLE
        issue(3'b001, 8'h05, 8'h00, 8'h00);
        chk("acq gnt_data0", gnt_data[0], 8'h85);
        chk("acq owner", owner, 2'd0);
        chk("acq owner_id", owner_id, 7'h05);
        step();
        // Non-owner acquire queues, release hands over two cycles later
        issue(3'b010, 8'h00, 8'h0A, 8'h00);
        chk("queued no rsp", gnt_valid[1], 1'b0);
        step();
        issue(3'b001, 8'h85, 8'h00, 8'h00);
        chk("release rsp", gnt_data[0], 8'h05);
        step();
        chk("handoff rsp valid", gnt_valid[1], 1'b1);
        chk("handoff rsp", gnt_data[1], 8'h8A);
        chk("handoff owner", owner, 2'd1);
        step();
        issue(3'b010, 8'h00, 8'h8A, 8'h00);
        step();
        // Release from IDLE is an error and moves rr back to 0
        issue(3'b100, 8'h00, 8'h00, 8'h83);
        chk("idle release err", gnt_data[2], 8'h43);
        step();
        // Simultaneous acquire with rr=0
        issue(3'b011, 8'h05, 8'h0A, 8'h00);
        chk("rr0 winner", gnt_data[0], 8'h85);
        chk("rr0 loser", gnt_valid[1], 1'b0);
        step();
        issue(3'b001, 8'h85, 8'h00, 8'h00);
        step();
        // Simultaneous acquire with rr=1, then idle timeout of 4
        hold = 16'd4;
        issue(3'b011, 8'h05, 8'h0A, 8'h00);
        chk("rr1 winner", gnt_data[1], 8'h8A);
        chk("rr1 owner", owner, 2'd1);
        for (int k = 1; k <= 4; k++) step();
        chk("timeout revoke", revoke, 3'b010);
        chk("timeout owner_valid", owner_valid, 1'b0);
        step();
        // Activity on the third cycle defers the revoke
        issue(3'b010, 8'h00, 8'h0A, 8'h00);
        activity = 3'b001;
        for (int k = 1; k <= 7; k++) begin
            activity[1] = (k == 3);
            step();
            if (k == 4) chk("deferred no revoke", revoke, 3'b000);
        end
        chk("deferred revoke", revoke, 3'b010);
        activity = '0;
        hold     = '0;
        step();
        // Release by a non-owner
        issue(3'b001, 8'h05, 8'h00, 8'h00);
        step();
        issue(3'b010, 8'h00, 8'h8A, 8'h00);
        chk("nonowner release err", gnt_data[1], 8'h4A);
        chk("nonowner owner kept", owner_valid, 1'b1);
        step();
        // Stalled response blocks further commands; then asynchronous reset
        gnt_ready = 3'b110;
        issue(3'b001, 8'h05, 8'h00, 8'h00);
        req_valid = 3'b011;
        req_data[1] = 8'h0A;
        step();
        step();
        chk("stalled ready0", req_ready[0], 1'b0);
        arst_ni = 1'b0;
        #2;
        chk("mid rst owner_valid", owner_valid, 1'b0);
        chk("mid rst gnt_valid", gnt_valid, 3'd0);
        chk("mid rst revoke", revoke, 3'd0);
        chk("mid rst owner_id", owner_id, 7'd0);
        model_reset();
        req_valid = '0;
        gnt_ready = '1;
        @(negedge clk) arst_ni = 1'b1;
        @(posedge clk) #1;
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: hold = 16'd0;
                    1: hold = 16'd1;
                    2: hold = 16'd3;
                    default: hold = 16'd6;
                endcase
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 45);
                req_data[i]  = {($urandom_range(0, 99) < 35), 7'($urandom)};
                gnt_ready[i] = ($urandom_range(0, 99) < 60);
                activity[i]  = ($urandom_range(0, 99) < 20);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
